joy_db15_tx: RTL
================

Name: joy_db15_tx

Overview:
- Responder side of the serial SNAC DB15 joystick link: emulates the adapter's parallel-in/serial-out shift chain.
- Two players' button vectors are loaded while the initiator holds joy_load low. One bit is then presented per joy_clk rising edge on joy_data.
- Used as a loopback source for the joy_db15 receiver in bench/board bring-up, and as the DB15 output when the core drives a second unit over the user port.
- Runs entirely in clk_sys. The initiator's joy_clk/joy_load are treated as asynchronous.

Parameters:
- BITS, 24: total frame length in bits; must be even and at least 2. Each player gets BITS/2 bits.
- CW, 5: width of the bit counter; must satisfy 2^CW > BITS.

Ports:
- clk_sys  in  1  system clock; all logic is in this domain.
- reset  in  1  synchronous, active-high reset.
- joystick1  in  BITS/2  player 1 buttons, active-high (bit0=right, 1=left, 2=down, 3=up, 4+=fire/start/coin as mapped by the core).
- joystick2  in  BITS/2  player 2 buttons, same layout as joystick1.
- joy_clk  in  1  shift clock from the initiator; asynchronous; idles high.
- joy_load  in  1  parallel-load strobe, active-low; asynchronous.
- joy_data  out  1  serial data to the initiator, active-low.
- frame_done  out  1  one-clk_sys pulse when the BITS-th bit has been shifted out.
- frame_abort  out  1  one-clk_sys pulse when load is asserted mid-frame.
- bit_count  out  CW  number of shift edges since the last load, saturating at BITS.

Behaviour:
- Synchroniser:
  - joy_clk and joy_load each pass through 2 flops. Both flops reset to 1.
  - Edge detection uses a third flop (clk_q). A rise is sync=1 and clk_q=0.
- Shift register sr, BITS wide:
  - Frame bit k (k=0 is transmitted first) = ~joystick1[k] for k < BITS/2, and ~joystick2[k-BITS/2] otherwise.
  - joy_data = sr[0] at all times, registered.
- Load (synchronised joy_load == 0):
  - sr reloads from the live joystick inputs every cycle (transparent, like a 74x165 PL).
  - bit_count is held at 0.
  - joy_clk edges are ignored while load is asserted.
- Shift (joy_load == 1 and a joy_clk rise):
  - sr shifts right, filling the top with 1.
  - bit_count increments if it is below BITS.
- Latency: joy_data changes 3 clk_sys cycles after the pin edge (2 synchroniser cycles plus 1 register cycle).
- Saturation:
  - The shift on which bit_count goes from BITS-1 to BITS raises frame_done for 1 cycle.
  - Further edges keep shifting 1s, so joy_data reads 1 (= released).
  - bit_count stays at BITS and frame_done does not re-pulse.
- Abort:
  - A synchronised falling edge of joy_load with 0 < bit_count < BITS pulses frame_abort for 1 cycle.
  - No pulse when bit_count is 0 or equal to BITS.
- Simultaneous load fall and clk rise in the same cycle: load wins; no shift, no count.
- Reset mid-frame:
  - sr becomes all 1s; joy_data=1; bit_count=0; frame_done=0; frame_abort=0; synchroniser flops=1.
  - The next frame begins only after a load low phase.
- Joystick inputs change after the load rises: no effect on the current frame.
- Minimum pin timing: joy_clk high and low phases must each be at least 2 clk_sys cycles. Narrower pulses may be missed. This is not flagged.

Optional Feature:
- Macro JOYDB15_TX_DEGLITCH_EN.
- Defined:
  - Each synchronised input must hold a new level for 3 consecutive clk_sys cycles before it is accepted.
  - Latency becomes 5 clk_sys cycles.
  - Minimum phase becomes 4 cycles.
  - Single-cycle glitches on joy_clk/joy_load produce no shift, load or abort.
- Undefined: no filter; behaviour as above.

Test Plan:
- Frame readout (BITS=24): joystick1=12'h015, joystick2=12'h800; load low 8 cycles, high; 24 clk rises, 8 cycles per phase. Required:
  - joy_data sequence (k=0..23) = 0,1,0,1,0,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,1,1,1,1,0.
  - frame_done pulses once, 3 cycles after the 24th rise.
  - bit_count=24.
- Overclock: 4 extra rises after a full frame -> joy_data=1 throughout; bit_count stays 24; no second frame_done.
- Mid-frame reload: load asserted after 10 rises -> frame_abort pulses exactly once; bit_count=0; a subsequent frame reads fresh inputs.
- Simultaneous edges: joy_load fall and joy_clk rise in the same cycle -> no shift; bit_count=0; no frame_abort if bit_count was 0.
- Reset mid-frame: reset 1 cycle after 5 rises -> next cycle joy_data=1, bit_count=0; further rises without a load keep joy_data=1.
- Deglitch (macro defined): 1-cycle low pulse on joy_load mid-frame -> no abort, bit_count unchanged. Undefined macro -> the same stimulus gives frame_abort=1.

Source files
------------

// File: rtl/joy_db15_tx.sv
// joy_db15_tx -- responder side of the serial SNAC DB15 joystick link.
// Emulates the adapter's parallel-in/serial-out chain: both players' buttons
// are captured while joy_load is low, then one bit per joy_clk rise is
// presented on joy_data (active-low). joy_clk/joy_load are asynchronous and
// are brought into clk_sys through two-flop synchronisers.
//
// Optional build macro: JOYDB15_TX_DEGLITCH_EN
//   When defined, each synchronised pin must hold a new level for three
//   cycles before it is accepted (pin-to-data latency 5 cycles, minimum
//   pin phase 4 cycles). When undefined, no filter is present.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | after reset; no frame captured yet, shift edges do not count
// ST_LOAD  | load strobe asserted; register follows the joystick inputs
// ST_SHIFT | frame in progress, 0 <= bit_count < BITS
// ST_FULL  | all BITS bits shifted; further edges shift in released (1) bits

module joy_db15_tx #(
   parameter int BITS = 24,
   parameter int CW   = 5
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [BITS/2-1:0]   joystick1,
   input  logic [BITS/2-1:0]   joystick2,
   input  logic                joy_clk,
   input  logic                joy_load,
   output logic                joy_data,
   output logic                frame_done,
   output logic                frame_abort,
   output logic [CW-1:0]       bit_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_FULL  = 2'd3;

   localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

   logic            clk_s1, clk_s2;
   logic            load_s1, load_s2;
   logic            clk_f, load_f;
   logic            clk_q, load_q;
   logic [1:0]      state;
   logic [BITS-1:0] sr;
   logic            clk_rise;
   logic            load_fall;
   logic            counting;

   // Two-flop synchronisers; both pins idle high so reset to 1.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         load_s1 <= 1'b1;
         load_s2 <= 1'b1;
      end else begin
         clk_s1  <= joy_clk;
         clk_s2  <= clk_s1;
         load_s1 <= joy_load;
         load_s2 <= load_s1;
      end
   end

`ifdef JOYDB15_TX_DEGLITCH_EN
   logic clk_seen, load_seen;

   // Accept a new synchronised level only after it has been sampled on two
   // consecutive edges (three cycles counting the cycle it appeared), so a
   // single-cycle glitch never reaches the edge detectors.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clk_f     <= 1'b1;
         clk_seen  <= 1'b0;
         load_f    <= 1'b1;
         load_seen <= 1'b0;
      end else begin
         if (clk_s2 != clk_f) begin
            if (clk_seen) begin
               clk_f    <= clk_s2;
               clk_seen <= 1'b0;
            end else begin
               clk_seen <= 1'b1;
            end
         end else begin
            clk_seen <= 1'b0;
         end
         if (load_s2 != load_f) begin
            if (load_seen) begin
               load_f    <= load_s2;
               load_seen <= 1'b0;
            end else begin
               load_seen <= 1'b1;
            end
         end else begin
            load_seen <= 1'b0;
         end
      end
   end
`else
   assign clk_f  = clk_s2;
   assign load_f = load_s2;
`endif

   assign clk_rise  = clk_f & ~clk_q;
   assign load_fall = ~load_f & load_q;
   // Edges only advance the counter once a frame has been captured.
   assign counting  = (state == ST_LOAD) || (state == ST_SHIFT);
   assign joy_data  = sr[0];

   // Edge-detect history flops.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clk_q  <= 1'b1;
         load_q <= 1'b1;
      end else begin
         clk_q  <= clk_f;
         load_q <= load_f;
      end
   end

   // Frame sequencing: load is transparent and has priority over a
   // coincident shift edge; the shift chain fills with 1s (released).
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= ST_IDLE;
         sr          <= '1;
         bit_count   <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         if (!load_f) begin
            state     <= ST_LOAD;
            sr        <= ~{joystick2, joystick1};
            bit_count <= '0;
            if (load_fall && (state == ST_SHIFT) && (bit_count != '0))
               frame_abort <= 1'b1;
         end else begin
            if (state == ST_LOAD)
               state <= ST_SHIFT;
            if (clk_rise) begin
               sr <= {1'b1, sr[BITS-1:1]};
               if (counting) begin
                  bit_count <= bit_count + 1'b1;
                  if (bit_count == CNT_LAST) begin
                     frame_done <= 1'b1;
                     state      <= ST_FULL;
                  end
               end
            end
         end
      end
   end

endmodule
